// File: rtl/pi_txn_queue_pkg.sv
// Shared definitions for the Pi-side 68K request queue.
// Provides register select codes, ADDR_HI/STATUS bit positions and the queued entry layout.
// No logic; it is imported by the queue top and its FIFO.
package pi_txn_queue_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_ADDR_LO = 2'd1,
    REG_ADDR_HI = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  // ADDR_HI write layout: D[15:13] fc, D[9] rw, D[8] byte size, D[7:0] addr[23:16]
  localparam int HI_FC_MSB    = 15;
  localparam int HI_FC_LSB    = 13;
  localparam int HI_RW        = 9;
  localparam int HI_SIZE      = 8;
  localparam int STATUS_FLUSH = 15;

  localparam int ENTRY_W = 47;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        siz;    // 1 = byte access
    logic        uds_n;
    logic        lds_n;
    logic [2:0]  fc;
  } entry_t;

endpackage

// File: rtl/pi_txn_queue_if.sv
// Command handshake between the Pi request queue (master) and the 68K bus-cycle FSM (slave).
// Head entry fields qualified by CMD_VALID; CMD_READY pops; CMD_DONE/CMD_BERR report completion.
// Pure wiring, no latency; backpressure is CMD_READY low.
interface pi_txn_queue_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [23:0] CMD_ADDR;
  logic [15:0] CMD_DATA;
  logic        CMD_RW;
  logic        CMD_UDS_n;
  logic        CMD_LDS_n;
  logic [2:0]  CMD_FC;
  logic        CMD_DONE;
  logic        CMD_BERR;

  modport master (
    output CMD_VALID, CMD_ADDR, CMD_DATA, CMD_RW, CMD_UDS_n, CMD_LDS_n, CMD_FC,
    input  CMD_READY, CMD_DONE, CMD_BERR
  );

  modport slave (
    input  CMD_VALID, CMD_ADDR, CMD_DATA, CMD_RW, CMD_UDS_n, CMD_LDS_n, CMD_FC,
    output CMD_READY, CMD_DONE, CMD_BERR
  );
endinterface

// File: rtl/pi_txn_fifo.sv
// Generic synchronous FIFO with push/pop/flush; head data read combinationally from memory.
// Latency: a push is visible at the head the cycle after it is written into an empty FIFO.
// Backpressure: push while full is accepted only if a pop happens in the same cycle; flush drops queued data.
// Ports: clk/rst_n; push + push_dat; pop; flush; head_dat, full, empty, empty_next.
module pi_txn_fifo
  import pi_txn_queue_pkg::*;
#(
  parameter int W     = ENTRY_W,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty,
  output logic         empty_next
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic         do_push, do_pop;

  // Extra MSB on each pointer separates full from empty when the low bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign do_pop  = pop & ~empty;
  // A push coinciding with a flush is discarded along with the queued entries.
  assign do_push = push & ~flush & (~full | do_pop);

  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (do_push) wr_nxt = wr_ptr + PTR_ONE;
    if (flush)       rd_nxt = wr_ptr;
    else if (do_pop) rd_nxt = rd_ptr + PTR_ONE;
  end

  assign empty_next = (wr_nxt == rd_nxt);
  assign head_dat   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  // Storage needs no reset: head contents are never used while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/pi_txn_queue.sv
// Pi-side front end of the 68K bridge: decodes Pi register writes and queues complete bus requests.
// Latency: PI_WR pin rise to CMD_VALID is 3 PI_CLK edges on an empty queue (2-flop sync + edge detect).
// Backpressure: CMD_READY low holds the head; a push into a full queue without a pop is dropped (Q_OVERFLOW).
// Ports: PI_CLK, RESET_n; Pi side PI_A/PI_WR/PI_RD/PI_D_IN; status PI_TXN_IN_PROGRESS, Q_OVERFLOW, Q_BERR;
//        cmd (master) carries the head entry, CMD_READY pop and CMD_DONE/CMD_BERR completion.
module pi_txn_queue
  import pi_txn_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 PI_CLK,
  input  logic                 RESET_n,
  input  logic [1:0]           PI_A,
  input  logic                 PI_WR,
  input  logic                 PI_RD,
  input  logic [15:0]          PI_D_IN,
  output logic                 PI_TXN_IN_PROGRESS,
  output logic                 Q_OVERFLOW,
  output logic                 Q_BERR,
  pi_txn_queue_if.master       cmd
);

  // [0] metastability flop, [1] synchronised level, [2] previous level for edge detect
  logic [2:0]  wr_sync, rd_sync;
  logic        wr_edge, rd_edge;
  reg_sel_e    sel;
  logic [15:0] addr_lo, data_stg;
  logic        push, flush, stat_rd, pop;
  logic        full, empty, empty_next;
  logic        inflight, inflight_next;
  logic        ovf_set, berr_set;
  entry_t      new_ent, head;
  logic [ENTRY_W-1:0] head_dat;

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wr_sync <= '0;
      rd_sync <= '0;
    end else begin
      wr_sync <= {wr_sync[1:0], PI_WR};
      rd_sync <= {rd_sync[1:0], PI_RD};
    end
  end

  assign wr_edge = wr_sync[1] & ~wr_sync[2];
  assign rd_edge = rd_sync[1] & ~rd_sync[2];
  assign sel     = reg_sel_e'(PI_A);

  assign push    = wr_edge && (sel == REG_ADDR_HI);
  assign flush   = wr_edge && (sel == REG_STATUS) && PI_D_IN[STATUS_FLUSH];
  assign stat_rd = rd_edge && (sel == REG_STATUS);

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      addr_lo  <= '0;
      data_stg <= '0;
    end else if (wr_edge) begin
      if (sel == REG_ADDR_LO) addr_lo  <= PI_D_IN;
      if (sel == REG_DATA)    data_stg <= PI_D_IN;
    end
  end

  // Byte accesses pick the strobe from A0 (even address = upper byte); words assert both.
  always_comb begin
    new_ent       = '0;
    new_ent.addr  = {PI_D_IN[7:0], addr_lo};
    new_ent.data  = data_stg;
    new_ent.rw    = PI_D_IN[HI_RW];
    new_ent.siz   = PI_D_IN[HI_SIZE];
    new_ent.fc    = PI_D_IN[HI_FC_MSB:HI_FC_LSB];
    new_ent.uds_n = PI_D_IN[HI_SIZE] ?  addr_lo[0] : 1'b0;
    new_ent.lds_n = PI_D_IN[HI_SIZE] ? ~addr_lo[0] : 1'b0;
  end

  pi_txn_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (PI_CLK),
    .rst_n      (RESET_n),
    .push       (push),
    .push_dat   (new_ent),
    .pop        (pop),
    .flush      (flush),
    .head_dat   (head_dat),
    .full       (full),
    .empty      (empty),
    .empty_next (empty_next)
  );

  assign head = head_dat;
  assign pop  = ~empty & cmd.CMD_READY;

  // Idle bus values while empty: strobes and RW deasserted-high, FC all ones.
  always_comb begin
    cmd.CMD_VALID = ~empty;
    cmd.CMD_ADDR  = '0;
    cmd.CMD_DATA  = '0;
    cmd.CMD_RW    = 1'b1;
    cmd.CMD_UDS_n = 1'b1;
    cmd.CMD_LDS_n = 1'b1;
    cmd.CMD_FC    = 3'b111;
    if (!empty) begin
      cmd.CMD_ADDR  = head.addr;
      cmd.CMD_DATA  = head.data;
      cmd.CMD_RW    = head.rw;
      // Word entries always carry both strobes low; the size bit keeps that explicit at the head.
      cmd.CMD_UDS_n = head.siz & head.uds_n;
      cmd.CMD_LDS_n = head.siz & head.lds_n;
      cmd.CMD_FC    = head.fc;
    end
  end

  // A pop in the same cycle as DONE starts the next cycle, so the flag stays set.
  assign inflight_next = pop | (inflight & ~cmd.CMD_DONE);

  assign ovf_set  = push & full & ~pop & ~flush;
  assign berr_set = cmd.CMD_DONE & cmd.CMD_BERR & inflight;

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      inflight           <= 1'b0;
      PI_TXN_IN_PROGRESS <= 1'b0;
      Q_OVERFLOW         <= 1'b0;
      Q_BERR             <= 1'b0;
    end else begin
      inflight           <= inflight_next;
      PI_TXN_IN_PROGRESS <= ~empty_next | inflight_next;
      // Set events win over a simultaneous STATUS read clear.
      Q_OVERFLOW         <= ovf_set  | (Q_OVERFLOW & ~stat_rd);
      Q_BERR             <= berr_set | (Q_BERR     & ~stat_rd);
    end
  end

endmodule

// File: tb/tb_pi_txn_queue.sv
module tb_pi_txn_queue;
  localparam int DEPTH = 4;
  localparam logic [45:0] IDLE = {24'h0, 16'h0, 1'b1, 1'b1, 1'b1, 3'b111};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pi_a = 2'd0;
  logic        pi_wr = 1'b0;
  logic        pi_rd = 1'b0;
  logic [15:0] pi_d = 16'h0;
  logic        txn, ovf, berr;

  pi_txn_queue_if cmd_if();

  pi_txn_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .PI_CLK             (clk),
    .RESET_n            (rst_n),
    .PI_A               (pi_a),
    .PI_WR              (pi_wr),
    .PI_RD              (pi_rd),
    .PI_D_IN            (pi_d),
    .PI_TXN_IN_PROGRESS (txn),
    .Q_OVERFLOW         (ovf),
    .Q_BERR             (berr),
    .cmd                (cmd_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: list of pending requests plus a few flags.
  logic [45:0] mq[$];
  logic [15:0] m_lo, m_data;
  bit          m_inf, m_ovf, m_berr;
  logic        lat_v2, lat_v3, lat_t3;

  function automatic logic [45:0] mk_ent(input logic [15:0] hi);
    logic u, l;
    if (hi[8]) begin u = m_lo[0]; l = ~m_lo[0]; end
    else       begin u = 1'b0;    l = 1'b0;     end
    return {hi[7:0], m_lo, m_data, hi[9], u, l, hi[15:13]};
  endfunction

  function automatic logic [45:0] head_obs();
    return {cmd_if.CMD_ADDR, cmd_if.CMD_DATA, cmd_if.CMD_RW,
            cmd_if.CMD_UDS_n, cmd_if.CMD_LDS_n, cmd_if.CMD_FC};
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".vld"},  {63'd0, cmd_if.CMD_VALID}, {63'd0, mq.size() != 0});
    chk({tag, ".txn"},  {63'd0, txn},  {63'd0, (mq.size() != 0) || m_inf});
    chk({tag, ".ovf"},  {63'd0, ovf},  {63'd0, m_ovf});
    chk({tag, ".berr"}, {63'd0, berr}, {63'd0, m_berr});
    chk({tag, ".head"}, {18'd0, head_obs()}, {18'd0, (mq.size() != 0) ? mq[0] : IDLE});
  endtask

  // One Pi register access; the strobe takes effect on the third clock edge after it rises.
  task automatic pi_op(input bit rd, input logic [1:0] a, input logic [15:0] d, input bit pop_act);
    bit popped;
    popped = 1'b0;
    @(negedge clk);
    pi_a = a; pi_d = d;
    if (rd) pi_rd = 1'b1; else pi_wr = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    lat_v2 = cmd_if.CMD_VALID;
    if (pop_act) begin
      if (mq.size() != 0) chk("pop_act.head", {18'd0, head_obs()}, {18'd0, mq[0]});
      cmd_if.CMD_READY = 1'b1;
    end
    @(posedge clk);
    if (pop_act && mq.size() != 0) begin
      void'(mq.pop_front());
      m_inf = 1'b1;
      popped = 1'b1;
    end
    if (rd) begin
      if (a == 2'd3) begin m_ovf = 1'b0; m_berr = 1'b0; end
    end else begin
      case (a)
        2'd0: m_data = d;
        2'd1: m_lo = d;
        2'd2: if (mq.size() < DEPTH || popped) mq.push_back(mk_ent(d)); else m_ovf = 1'b1;
        default: if (d[15]) mq.delete();
      endcase
    end
    @(negedge clk);
    lat_v3 = cmd_if.CMD_VALID;
    lat_t3 = txn;
    cmd_if.CMD_READY = 1'b0;
    pi_wr = 1'b0;
    pi_rd = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_pop();
    @(negedge clk);
    if (mq.size() != 0) chk("pop.head", {18'd0, head_obs()}, {18'd0, mq[0]});
    cmd_if.CMD_READY = 1'b1;
    @(posedge clk);
    if (mq.size() != 0) begin void'(mq.pop_front()); m_inf = 1'b1; end
    @(negedge clk);
    cmd_if.CMD_READY = 1'b0;
  endtask

  task automatic do_done(input logic be);
    @(negedge clk);
    cmd_if.CMD_DONE = 1'b1;
    cmd_if.CMD_BERR = be;
    @(posedge clk);
    if (m_inf) begin m_inf = 1'b0; if (be) m_berr = 1'b1; end
    @(negedge clk);
    cmd_if.CMD_DONE = 1'b0;
    cmd_if.CMD_BERR = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_if.CMD_READY = 1'b0;
    cmd_if.CMD_DONE  = 1'b0;
    cmd_if.CMD_BERR  = 1'b0;
    m_lo = '0; m_data = '0; m_inf = 0; m_ovf = 0; m_berr = 0;

    repeat (3) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_state("post_rst");

    // Word write with latency check
    pi_op(0, 2'd1, 16'h1234, 0);
    pi_op(0, 2'd0, 16'hBEEF, 0);
    pi_op(0, 2'd2, 16'hA012, 0);
    chk("lat.edge2", {63'd0, lat_v2}, 64'd0);
    chk("lat.edge3", {63'd0, lat_v3}, 64'd1);
    chk("lat.txn",   {63'd0, lat_t3}, 64'd1);
    chk("word.addr", {40'd0, cmd_if.CMD_ADDR}, 64'h121234);
    chk("word.data", {48'd0, cmd_if.CMD_DATA}, 64'hBEEF);
    chk("word.strb", {61'd0, cmd_if.CMD_RW, cmd_if.CMD_UDS_n, cmd_if.CMD_LDS_n}, 64'd0);
    chk("word.fc",   {61'd0, cmd_if.CMD_FC}, 64'd5);
    check_state("word");
    do_pop();
    check_state("word.pop");
    do_done(0);
    check_state("word.done");

    // Byte read at odd address
    pi_op(0, 2'd1, 16'h0001, 0);
    pi_op(0, 2'd2, 16'h0300, 0);
    chk("byte.strb", {61'd0, cmd_if.CMD_RW, cmd_if.CMD_UDS_n, cmd_if.CMD_LDS_n}, 64'b110);
    chk("byte.addr", {40'd0, cmd_if.CMD_ADDR}, 64'h000001);
    do_pop();
    repeat (4) @(negedge clk);
    chk("byte.txn_hold", {63'd0, txn}, 64'd1);
    do_done(0);
    chk("byte.txn_fall", {63'd0, txn}, 64'd0);
    check_state("byte.done");

    // Overflow: 5 pushes into 4 entries
    for (int i = 0; i < 5; i++) pi_op(0, 2'd2, 16'h0010 + 16'(i), 0);
    chk("ovf.set", {63'd0, ovf}, 64'd1);
    check_state("ovf.full");
    for (int i = 0; i < 4; i++) begin
      do_pop();
      do_done(0);
      check_state("ovf.drain");
    end
    pi_op(1, 2'd3, 16'h0000, 0);
    chk("ovf.clear", {63'd0, ovf}, 64'd0);

    // Full queue with simultaneous push and pop, 10 entries across pointer wrap
    for (int i = 0; i < 10; i++) begin
      pi_op(0, 2'd1, 16'(i * 3), 0);
      pi_op(0, 2'd2, 16'h2040 + 16'(i), mq.size() == DEPTH);
      check_state("wrap.push");
    end
    chk("wrap.no_ovf", {63'd0, ovf}, 64'd0);
    for (int i = 0; i < 4; i++) do_pop();
    check_state("wrap.drained");
    do_done(0);

    // Bus error flag
    pi_op(0, 2'd2, 16'h0001, 0);
    do_pop();
    do_done(1);
    chk("berr.set", {63'd0, berr}, 64'd1);
    pi_op(1, 2'd3, 16'h0000, 0);
    chk("berr.clear", {63'd0, berr}, 64'd0);

    // Flush with one in flight and three queued
    for (int i = 0; i < 4; i++) pi_op(0, 2'd2, 16'h0050 + 16'(i), 0);
    do_pop();
    pi_op(0, 2'd3, 16'h8000, 0);
    chk("flush.vld", {63'd0, lat_v3}, 64'd0);
    chk("flush.txn", {63'd0, lat_t3}, 64'd1);
    do_done(0);
    check_state("flush.done");

    // Randomized mix of all operations
    for (int i = 0; i < 150; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
        0: pi_op(0, 2'd0, 16'($urandom), 0);
        1: pi_op(0, 2'd1, 16'($urandom), 0);
        2, 3, 4: pi_op(0, 2'd2, 16'($urandom), 1'($urandom_range(0, 1)));
        5: if ($urandom_range(0, 3) == 0) pi_op(0, 2'd3, 16'h8000 | 16'($urandom_range(0, 255)), 0);
           else pi_op(0, 2'd3, 16'($urandom_range(0, 32767)), 0);
        6: pi_op(1, 2'd3, 16'h0000, 0);
        7: pi_op(1, 2'($urandom_range(0, 2)), 16'h0000, 0);
        8: do_pop();
        default: if (m_inf) do_done(1'($urandom_range(0, 1))); else do_pop();
      endcase
      check_state("rnd");
    end

    // Asynchronous reset mid-cycle with one in flight and two queued
    while (mq.size() != 0) do_pop();
    if (m_inf) do_done(0);
    pi_op(0, 2'd1, 16'h00F1, 0);
    pi_op(0, 2'd0, 16'h5A5A, 0);
    for (int i = 0; i < 3; i++) pi_op(0, 2'd2, 16'h0160 + 16'(i), 0);
    do_pop();
    check_state("rst.pre");
    @(posedge clk);
    #2 rst_n = 1'b0;
    mq.delete(); m_inf = 0; m_ovf = 0; m_berr = 0; m_lo = '0; m_data = '0;
    #1 check_state("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    do_done(0);
    check_state("rst.done_ignored");
    pi_op(0, 2'd2, 16'h0100, 0);
    check_state("rst.staging_cleared");
    do_pop();
    do_done(0);
    check_state("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
